// File: rtl/mod0_sink.sv
// Framed nibble sink: strips headers, checks frame structure, buffers payload in a show-ahead FIFO.
// Optional MOD0_SINK_ERRCNT_EN adds an 8-bit saturating error-event counter on OV_ERRCNT.
module mod0_sink #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] IV1_3,
  input  logic       IB_VLD,
  output logic       OB_RDY,
  output logic [2:0] OV2_2,
  output logic       OB_LAST,
  output logic       OB_VLD,
  input  logic       IB_RDY,
  output logic       OB_ERR,
  input  logic       IB_ERR_CLR
`ifdef MOD0_SINK_ERRCNT_EN
  ,
  output logic [7:0] OV_ERRCNT
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [2:0]    r_rem;
  logic [2:0]    w_rem_nx;
  logic          w_push;
  logic          w_err;
  logic [3:0]    w_wdata;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_acc;
  logic          w_pop;
  logic          w_hdr;
  logic [2:0]    w_n;
  logic [3:0]    w_head;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign OB_RDY  = !RST && !w_full;
  assign w_acc   = IB_VLD && OB_RDY;
  assign w_pop   = !w_empty && IB_RDY;
  assign w_hdr   = IV1_3[3];
  assign w_n     = IV1_3[2:0];
  assign w_head  = r_mem[r_rd];

  assign OB_VLD  = !w_empty;
  assign OV2_2   = w_empty ? 3'd0 : w_head[2:0];
  assign OB_LAST = w_empty ? 1'b0 : w_head[3];

  // Frame parser state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_rem   <= w_rem_nx;
    end
  end

  // Frame parser next state; a header seen mid-frame restarts the frame
  always_comb begin
    w_state_nx = r_state;
    w_rem_nx   = r_rem;
    w_push     = 1'b0;
    w_err      = 1'b0;
    w_wdata    = {1'b0, w_n};
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (w_hdr && (w_n != 3'd0)) begin
            w_state_nx = S_PAYLOAD;
            w_rem_nx   = w_n;
          end else begin
            w_err = 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (!w_hdr) begin
            w_push   = 1'b1;
            w_wdata  = {(r_rem == 3'd1), w_n};
            w_rem_nx = r_rem - 3'd1;
            if (r_rem == 3'd1) w_state_nx = S_IDLE;
          end else begin
            w_err    = 1'b1;
            w_rem_nx = w_n;
            if (w_n == 3'd0) w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Payload storage
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= w_wdata;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear
  always_ff @(posedge CLK) begin
    if (RST)             OB_ERR <= 1'b0;
    else if (w_err)      OB_ERR <= 1'b1;
    else if (IB_ERR_CLR) OB_ERR <= 1'b0;
  end

`ifdef MOD0_SINK_ERRCNT_EN
  // Saturating error-event counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      OV_ERRCNT <= 8'd0;
    end else if (w_err) begin
      if (IB_ERR_CLR)              OV_ERRCNT <= 8'd1;
      else if (OV_ERRCNT != 8'hFF) OV_ERRCNT <= OV_ERRCNT + 8'd1;
    end else if (IB_ERR_CLR) begin
      OV_ERRCNT <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_mod0_sink.sv
// Scoreboard bench for mod0_sink: directed test-plan scenarios followed by randomized frames.
// Build with MOD0_SINK_ERRCNT_EN defined to also check the error counter.
module tb_mod0_sink;

  localparam int unsigned DEPTH = 4;
  localparam int BOUND = 200;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] IV1_3 = 4'h0;
  logic       IB_VLD = 1'b0;
  logic       OB_RDY;
  logic [2:0] OV2_2;
  logic       OB_LAST;
  logic       OB_VLD;
  logic       IB_RDY = 1'b1;
  logic       OB_ERR;
  logic       IB_ERR_CLR = 1'b0;
`ifdef MOD0_SINK_ERRCNT_EN
  logic [7:0] OV_ERRCNT;
`endif

  mod0_sink #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .IV1_3(IV1_3), .IB_VLD(IB_VLD), .OB_RDY(OB_RDY),
    .OV2_2(OV2_2), .OB_LAST(OB_LAST), .OB_VLD(OB_VLD), .IB_RDY(IB_RDY),
    .OB_ERR(OB_ERR), .IB_ERR_CLR(IB_ERR_CLR)
`ifdef MOD0_SINK_ERRCNT_EN
    , .OV_ERRCNT(OV_ERRCNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;        // 0: IB_RDY low, 1: IB_RDY high, 2: random

  // reference model state: expected FIFO words {last,data}, frame progress, error status
  logic [3:0] exp_q[$];
  logic [3:0] got[$];
  logic [3:0] want[$];
  int frame_left = 0;
  int m_err = 0;
  int m_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // input-side observer: decide acceptance before the edge, update the model at the edge
  initial begin
    logic acc_s, clr_s, rst_s, err_ev;
    logic [3:0] nib_s;
    forever begin
      @(negedge CLK);
      acc_s = IB_VLD && OB_RDY;
      clr_s = IB_ERR_CLR;
      rst_s = RST;
      nib_s = IV1_3;
      @(posedge CLK);
      if (rst_s) begin
        exp_q.delete();
        frame_left = 0;
        m_err = 0;
        m_cnt = 0;
      end else begin
        err_ev = 1'b0;
        if (acc_s) begin
          if (nib_s[3]) begin
            if (frame_left != 0 || nib_s[2:0] == 3'd0) err_ev = 1'b1;
            frame_left = int'(nib_s[2:0]);
          end else if (frame_left == 0) begin
            err_ev = 1'b1;
          end else begin
            exp_q.push_back({(frame_left == 1), nib_s[2:0]});
            frame_left--;
          end
        end
        if (err_ev) m_err = 1;
        else if (clr_s) m_err = 0;
        if (err_ev) m_cnt = clr_s ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        else if (clr_s) m_cnt = 0;
      end
    end
  end

  // output-side monitor: compare handshake, flags and popped words against the model
  initial begin
    logic [3:0] w;
    forever begin
      @(negedge CLK);
      if (RST) begin
        check("ob_rdy_in_reset", 32'(OB_RDY), 32'd0);
      end else begin
        check("ob_vld", 32'(OB_VLD), 32'(exp_q.size() != 0));
        check("ob_rdy", 32'(OB_RDY), 32'(exp_q.size() < DEPTH));
        check("ob_err", 32'(OB_ERR), 32'(m_err));
`ifdef MOD0_SINK_ERRCNT_EN
        check("errcnt", 32'(OV_ERRCNT), 32'(m_cnt));
`endif
        if (OB_VLD && IB_RDY && exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("data", 32'(OV2_2), 32'(w[2:0]));
          check("last", 32'(OB_LAST), 32'(w[3]));
          got.push_back({OB_LAST, OV2_2});
        end
      end
    end
  end

  // downstream ready generator
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       IB_RDY = 1'b0;
        1:       IB_RDY = 1'b1;
        default: IB_RDY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic [3:0] nib);
    int n;
    n = 0;
    IV1_3 = nib;
    IB_VLD = 1'b1;
    @(negedge CLK);
    while (!OB_RDY && n < BOUND) begin
      n++;
      @(negedge CLK);
    end
    if (!OB_RDY) begin
      errors++;
      $display("FAIL send_timeout: OB_RDY stuck at 0, nibble %0h not accepted", nib);
    end
    @(posedge CLK);
    #1;
    IB_VLD = 1'b0;
    IB_ERR_CLR = 1'b0;
  endtask

  task automatic idle(input int n, input logic clr);
    IB_ERR_CLR = clr;
    repeat (n) begin
      @(posedge CLK);
      #1;
      IB_ERR_CLR = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || OB_VLD) && n < BOUND) begin
      n++;
      @(posedge CLK);
      #1;
    end
    checks++;
    if (exp_q.size() != 0 || OB_VLD) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still expected, OB_VLD=%0b", exp_q.size(), OB_VLD);
    end
    idle(1, 1'b0);
  endtask

  task automatic cmp_got(input string nm);
    check({nm, "_count"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check({nm, "_word"}, 32'(got[i]), 32'(want[i]));
    got.delete();
    want.delete();
  endtask

  initial begin
    int n;
    logic [3:0] nib;
    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_vld", 32'(OB_VLD), 32'd0);
    check("rst_data", 32'(OV2_2), 32'd0);
    check("rst_last", 32'(OB_LAST), 32'd0);
    check("rst_err", 32'(OB_ERR), 32'd0);
`ifdef MOD0_SINK_ERRCNT_EN
    check("rst_errcnt", 32'(OV_ERRCNT), 32'd0);
`endif
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rdy_after_rst", 32'(OB_RDY), 32'd1);
    @(posedge CLK);
    #1;

    // single frame
    got.delete();
    send(4'hB); send(4'h1); send(4'h2); send(4'h7);
    drain();
    want = '{4'h1, 4'h2, 4'hF};
    cmp_got("single_frame");
    check("single_err", 32'(OB_ERR), 32'd0);

    // backpressure: FIFO fills, then downstream releases
    rdy_mode = 0;
    fork
      begin
        send(4'hF);
        for (int i = 1; i <= 7; i++) send(4'(i));
      end
      begin
        repeat (10) @(negedge CLK);
        check("bp_rdy_low", 32'(OB_RDY), 32'd0);
        check("bp_vld_high", 32'(OB_VLD), 32'd1);
        rdy_mode = 1;
      end
    join
    drain();
    want = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
    cmp_got("backpressure");

    // truncated frame
    send(4'hA); send(4'h5); send(4'h9); send(4'h3);
    drain();
    want = '{4'h5, 4'hB};
    cmp_got("truncation");
    check("trunc_err", 32'(OB_ERR), 32'd1);
`ifdef MOD0_SINK_ERRCNT_EN
    check("trunc_cnt", 32'(OV_ERRCNT), 32'd1);
`endif

    // bad headers, then error coincident with clear
    idle(2, 1'b1);
    send(4'h8); send(4'h4);
    idle(2, 1'b0);
    check("bad_hdr_nothing_out", 32'(got.size()), 32'd0);
    check("bad_hdr_err", 32'(OB_ERR), 32'd1);
`ifdef MOD0_SINK_ERRCNT_EN
    check("bad_hdr_cnt", 32'(OV_ERRCNT), 32'd2);
`endif
    IB_ERR_CLR = 1'b1;
    send(4'h4);
    idle(1, 1'b0);
    check("err_clr_same_cycle", 32'(OB_ERR), 32'd1);
`ifdef MOD0_SINK_ERRCNT_EN
    check("err_clr_same_cnt", 32'(OV_ERRCNT), 32'd1);
`endif

    // counter saturation
    idle(2, 1'b1);
    for (int i = 0; i < 300; i++) send(4'h4);
    idle(1, 1'b0);
    check("sat_err", 32'(OB_ERR), 32'd1);
`ifdef MOD0_SINK_ERRCNT_EN
    check("sat_cnt", 32'(OV_ERRCNT), 32'd255);
`endif

    // reset mid-frame discards buffered payload
    got.delete();
    rdy_mode = 0;
    idle(1, 1'b0);
    send(4'hC); send(4'h1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    rdy_mode = 1;
    send(4'h9); send(4'h6);
    drain();
    want = '{4'hE};
    cmp_got("reset_mid_frame");
    check("reset_err", 32'(OB_ERR), 32'd0);

    // randomized frames with occasional corruption, gaps, clears and resets
    rdy_mode = 2;
    for (int f = 0; f < 250; f++) begin
      n = int'($urandom_range(1, 7));
      if ($urandom_range(0, 99) < 2) begin
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
      end
      send({1'b1, 3'(n)});
      for (int i = 0; i < n; i++) begin
        nib = {1'b0, 3'($urandom_range(0, 7))};
        if ($urandom_range(0, 99) < 8) nib = 4'($urandom_range(0, 15));
        send(nib);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), 1'($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 9) == 0) idle(1, 1'b1);
    end
    rdy_mode = 1;
    drain();
    got.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
